// File: rtl/bar_pkg.sv
// Shared types and default sizing for the lab bar-shifter family.
// Holds the run-state and direction encodings used by the shifter and its bench.
package bar_pkg;

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_STEP_DIV = 1;

endpackage

// File: rtl/step_prescaler.sv
// Step-rate divider: counts enabled cycles 0..DIV-1 and flags the last one as a tick.
// Latency: tick is combinational from the registered count; first tick DIV enabled cycles after clear.
// Backpressure: none; en pauses the count, clr forces it to zero and suppresses the tick.
module step_prescaler #(
    parameter int  DIV   = 1,
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bar_shifter_param.sv
// Thermometer LED bar that fills/drains one segment per prescaled tick; BAR_SHIFTER_BOUNCE_EN adds auto-bounce.
// Latency: first level change STEP_DIV edges after enable is first sampled high; out/position/step registered.
// Backpressure: none; enable low clears the bar on the next edge, ends saturate without wrapping.
module bar_shifter_param
    import bar_pkg::*;
#(
    parameter int  WIDTH    = DEF_WIDTH,
    parameter int  STEP_DIV = DEF_STEP_DIV,
    localparam int LVL_W    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             increase,
`ifdef BAR_SHIFTER_BOUNCE_EN
    input  logic             auto_mode,
`endif
    output logic [WIDTH-1:0] out,
    output logic [LVL_W-1:0] position,
    output logic             full,
    output logic             empty,
    output logic             step
);

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(WIDTH);

    state_t           state_q, state_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             step_q, step_d;
    logic             run_en;
    logic             tick;
    logic             go_up;

    // Prescaler only advances on cycles already in RUN, so it restarts from 0 on entry.
    assign run_en = (state_q == ST_RUN) && enable;

    step_prescaler #(
        .DIV (STEP_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run_en),
        .clr   (!run_en),
        .tick  (tick)
    );

`ifdef BAR_SHIFTER_BOUNCE_EN
    dir_t dir_q, dir_d;
    assign go_up = auto_mode ? (dir_q == DIR_UP) : increase;
`else
    assign go_up = increase;
`endif

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        step_d  = 1'b0;
`ifdef BAR_SHIFTER_BOUNCE_EN
        dir_d   = dir_q;
`endif
        if (!enable) begin
            state_d = ST_OFF;
            lvl_d   = '0;
`ifdef BAR_SHIFTER_BOUNCE_EN
            dir_d   = DIR_UP;
`endif
        end else if (state_q == ST_OFF) begin
            state_d = ST_RUN;
        end else if (tick) begin
            if (go_up && (lvl_q != LVL_FULL)) begin
                lvl_d  = lvl_q + 1'b1;
                step_d = 1'b1;
`ifdef BAR_SHIFTER_BOUNCE_EN
                if (auto_mode && (lvl_d == LVL_FULL)) begin
                    dir_d = DIR_DOWN;
                end
`endif
            end else if (!go_up && (lvl_q != '0)) begin
                lvl_d  = lvl_q - 1'b1;
                step_d = 1'b1;
`ifdef BAR_SHIFTER_BOUNCE_EN
                if (auto_mode && (lvl_d == '0)) begin
                    dir_d = DIR_UP;
                end
`endif
            end else begin
`ifdef BAR_SHIFTER_BOUNCE_EN
                // Stuck at an end pointing outward (auto engaged after manual saturation): turn around.
                if (auto_mode) begin
                    dir_d = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
                end
`endif
            end
        end
    end

    always_comb begin
        out_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            out_d[i] = (LVL_W'(i) < lvl_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            lvl_q   <= '0;
            out_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            out_q   <= out_d;
            step_q  <= step_d;
        end
    end

`ifdef BAR_SHIFTER_BOUNCE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir_q <= DIR_UP;
        end else begin
            dir_q <= dir_d;
        end
    end
`endif

    assign out      = out_q;
    assign position = lvl_q;
    assign full     = (lvl_q == LVL_FULL);
    assign empty    = (lvl_q == '0);
    assign step     = step_q;

endmodule
